instr_fetch_unit: RTL and testbench

//   Instruction-fetch stage directly upstream of the IF/ID pipeline register.
//   - Owns the PC and requests one 16-bit instruction per fetch from a variable-latency instruction memory.
//   - Presents the instruction and its address to IF/ID, inserting NOP bubbles while waiting on memory.
//   - Honours the pipeline stall, and redirects on taken branches/jumps, raising the flush strobe towards IF/ID.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_hold_reg.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - Default address / instruction widths.
//   - NOP encoding inserted as a bubble towards IF/ID.
//   - Request FSM state encoding and a helper telling whether a state
//     drives a memory request.
package fetch_pkg;

    localparam int          ADDR_W_DEF  = 16;
    localparam int          INSTR_W_DEF = 16;
    localparam logic [15:0] NOP_INSTR   = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // no request outstanding
        ST_FETCH   = 2'd1,  // request for pc outstanding
        ST_DISCARD = 2'd2,  // finishing a request orphaned by a redirect
        ST_PEND    = 2'd3   // one completed fetch parked while stalled
    } fetch_state_e;

    // FETCH and DISCARD are the only states with a live memory request.
    function automatic logic state_has_req(input fetch_state_e st);
        return (st == ST_FETCH) || (st == ST_DISCARD);
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// One-entry holding register for a completed {instruction, address} pair.
// Used to park a fetch that returned while the pipeline was stalled.
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   load                capture instr_in/addr_in and mark the entry valid
//   clear               empty the entry (wins over load)
//   instr_in, addr_in   payload to capture
//   instr_out, addr_out held payload
//   valid_out           entry holds a payload
module fetch_hold_reg #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [ADDR_W-1:0]  addr_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  addr_out,
    output logic               valid_out
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic               valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            addr_d  = addr_in;
            valid_d = 1'b1;
        end
    end

    // NOTE: the payload is reset along with the valid bit so the parked
    // entry never carries X into the output register after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign addr_out  = addr_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, issues one request at a time to a variable-latency
// instruction memory, inserts NOP bubbles while waiting, honours stall and
// redirects on taken branches with a one-cycle flush pulse.
// Ports:
//   clock, reset                  rising-edge clock, async active-high reset
//   stall                         downstream hold; IF outputs frozen
//   branch_taken, branch_target   redirect request and new PC
//   imem_req, imem_addr           memory request / address (held until ready)
//   imem_ready, imem_rdata        memory completion and returned instruction
//   instruction_out               instruction (or NOP) to IF/ID
//   instr_addr_out                address of instruction_out
//   fetch_valid                   instruction_out is a real fetch
//   if_flush_out                  one-cycle pulse on redirect
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [ADDR_W-1:0]  instr_addr_out,
    output logic               fetch_valid,
    output logic               if_flush_out
);

    localparam logic [ADDR_W-1:0]  PC_STEP = ADDR_W'(PC_INC);
    localparam logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  addr_out_q, addr_out_d;
    logic               valid_q, valid_d;
    logic               flush_q, flush_d;

    logic               hold_load, hold_clear, hold_valid;
    logic [INSTR_W-1:0] hold_instr;
    logic [ADDR_W-1:0]  hold_addr;

    logic               capture;
    logic [INSTR_W-1:0] cap_instr;
    logic [ADDR_W-1:0]  cap_addr;

    fetch_hold_reg #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W)
    ) u_pend (
        .clock     (clock),
        .reset     (reset),
        .load      (hold_load),
        .clear     (hold_clear),
        .instr_in  (imem_rdata),
        .addr_in   (pc_q),
        .instr_out (hold_instr),
        .addr_out  (hold_addr),
        .valid_out (hold_valid)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case/if tree can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        addr_out_d = addr_out_q;
        valid_d    = valid_q;
        flush_d    = 1'b0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        capture    = 1'b0;
        cap_instr  = imem_rdata;
        cap_addr   = pc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!stall) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // In FETCH the outstanding request is always for pc_q; keep a
                // copy so an orphaned request can finish after pc moves.
                req_addr_d = pc_q;
                if (imem_ready) begin
                    pc_d = pc_q + PC_STEP;
                    if (stall) begin
                        hold_load = 1'b1;
                        state_d   = ST_PEND;
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (imem_ready) state_d = stall ? ST_IDLE : ST_FETCH;
            end
            ST_PEND: begin
                if (!stall) begin
                    capture    = hold_valid;
                    cap_instr  = hold_instr;
                    cap_addr   = hold_addr;
                    hold_clear = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Output register: capture, bubble, or freeze under stall.
        if (capture) begin
            instr_d    = cap_instr;
            addr_out_d = cap_addr;
            valid_d    = 1'b1;
        end else if (!stall) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end

        // Redirect overrides stall and any capture computed above.
        if (branch_taken) begin
            pc_d       = branch_target;
            flush_d    = 1'b1;
            instr_d    = NOP;
            valid_d    = 1'b0;
            hold_load  = 1'b0;
            hold_clear = 1'b1;
            unique case (state_q)
                ST_FETCH: begin
                    if (imem_ready) state_d = stall ? ST_IDLE : ST_FETCH;
                    else            state_d = ST_DISCARD;
                end
                ST_PEND: state_d = stall ? ST_IDLE : ST_FETCH;
                default: ; // IDLE/DISCARD keep their normal transition
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= '0;
            addr_out_q <= '0;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            addr_out_q <= addr_out_d;
            valid_q    <= valid_d;
            flush_q    <= flush_d;
        end
    end

    assign imem_req        = state_has_req(state_q);
    assign imem_addr       = (state_q == ST_DISCARD) ? req_addr_q : pc_q;
    assign instruction_out = instr_q;
    assign instr_addr_out  = addr_out_q;
    assign fetch_valid     = valid_q;
    assign if_flush_out    = flush_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] instruction_out;
    logic [15:0] instr_addr_out;
    logic        fetch_valid;
    logic        if_flush_out;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instruction_out (instruction_out),
        .instr_addr_out  (instr_addr_out),
        .fetch_valid     (fetch_valid),
        .if_flush_out    (if_flush_out)
    );

    always #5 clock = ~clock;

    // Advance one cycle; inputs are then driven and outputs sampled 1 ns
    // after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Checks the full IF/ID-facing output set at once.
    task automatic check_out(input string tag, input logic [15:0] instr,
                             input logic [15:0] addr, input logic valid);
        check({tag, ".instr"}, {16'h0, instruction_out}, {16'h0, instr});
        check({tag, ".addr"},  {16'h0, instr_addr_out},  {16'h0, addr});
        check({tag, ".valid"}, {31'h0, fetch_valid},     {31'h0, valid});
    endtask

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        imem_ready    = 1'b0;
        imem_rdata    = 16'h0000;
        tick();
        tick();
        reset = 1'b0;
        check("rst.req",   {31'h0, imem_req}, 32'h0);
        check("rst.iaddr", {16'h0, imem_addr}, 32'h0);
        check("rst.flush", {31'h0, if_flush_out}, 32'h0);
        check_out("rst", 16'h0000, 16'h0000, 1'b0);

        // 1: reset while a request is pending
        tick();
        check("t1.req_on", {31'h0, imem_req}, 32'h1);
        tick();
        reset = 1'b1;
        #1;
        check("t1.req_off", {31'h0, imem_req}, 32'h0);
        check("t1.iaddr",   {16'h0, imem_addr}, 32'h0);
        check_out("t1", 16'h0000, 16'h0000, 1'b0);
        tick();
        reset = 1'b0;

        // 2: sequential fetch with a 1-cycle memory
        tick();
        check("t2.req",  {31'h0, imem_req}, 32'h1);
        check("t2.a0",   {16'h0, imem_addr}, 32'h0000);
        imem_ready = 1'b1;
        imem_rdata = 16'hA000;
        tick();
        check_out("t2.o0", 16'hA000, 16'h0000, 1'b1);
        check("t2.a1", {16'h0, imem_addr}, 32'h0001);
        imem_rdata = 16'hA001;
        tick();
        check_out("t2.o1", 16'hA001, 16'h0001, 1'b1);
        check("t2.a2", {16'h0, imem_addr}, 32'h0002);
        imem_rdata = 16'hA002;
        tick();
        check_out("t2.o2", 16'hA002, 16'h0002, 1'b1);
        check("t2.a3", {16'h0, imem_addr}, 32'h0003);
        imem_rdata = 16'hA003;
        tick();
        check_out("t2.o3", 16'hA003, 16'h0003, 1'b1);
        check("t2.a4", {16'h0, imem_addr}, 32'h0004);
        imem_ready = 1'b0;
        tick();
        check_out("t2.bub", 16'h0000, 16'h0003, 1'b0);
        imem_ready = 1'b1;
        imem_rdata = 16'hA004;
        tick();
        check_out("t2.o4", 16'hA004, 16'h0004, 1'b1);

        // 3: 3-cycle memory on address 5
        check("t3.a5_c1", {16'h0, imem_addr}, 32'h0005);
        imem_ready = 1'b0;
        tick();
        check("t3.a5_c2", {16'h0, imem_addr}, 32'h0005);
        check_out("t3.bub1", 16'h0000, 16'h0004, 1'b0);
        tick();
        check("t3.a5_c3", {16'h0, imem_addr}, 32'h0005);
        check("t3.req",   {31'h0, imem_req}, 32'h1);
        check_out("t3.bub2", 16'h0000, 16'h0004, 1'b0);
        imem_ready = 1'b1;
        imem_rdata = 16'hB005;
        tick();
        check_out("t3.o5", 16'hB005, 16'h0005, 1'b1);
        check("t3.a6", {16'h0, imem_addr}, 32'h0006);

        // 4: stall while address 7 returns
        imem_rdata = 16'hA006;
        tick();
        check_out("t4.o6", 16'hA006, 16'h0006, 1'b1);
        check("t4.a7", {16'h0, imem_addr}, 32'h0007);
        stall      = 1'b1;
        imem_rdata = 16'hC007;
        tick();
        check_out("t4.frz1", 16'hA006, 16'h0006, 1'b1);
        check("t4.req_off", {31'h0, imem_req}, 32'h0);
        imem_ready = 1'b0;
        tick();
        check_out("t4.frz2", 16'hA006, 16'h0006, 1'b1);
        check("t4.req_off2", {31'h0, imem_req}, 32'h0);
        stall = 1'b0;
        tick();
        check_out("t4.o7", 16'hC007, 16'h0007, 1'b1);
        check("t4.req", {31'h0, imem_req}, 32'h1);
        check("t4.a8",  {16'h0, imem_addr}, 32'h0008);

        // 5: redirect while address 9 is outstanding
        imem_ready = 1'b1;
        imem_rdata = 16'hA008;
        tick();
        check_out("t5.o8", 16'hA008, 16'h0008, 1'b1);
        imem_ready = 1'b0;
        tick();
        check("t5.a9", {16'h0, imem_addr}, 32'h0009);
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        tick();
        branch_taken = 1'b0;
        check("t5.flush1", {31'h0, if_flush_out}, 32'h1);
        check("t5.disc_a", {16'h0, imem_addr}, 32'h0009);
        check("t5.disc_r", {31'h0, imem_req}, 32'h1);
        check("t5.valid",  {31'h0, fetch_valid}, 32'h0);
        tick();
        check("t5.flush0", {31'h0, if_flush_out}, 32'h0);
        check("t5.disc_a2", {16'h0, imem_addr}, 32'h0009);
        imem_ready = 1'b1;
        imem_rdata = 16'hDEAD;
        tick();
        check_out("t5.drop", 16'h0000, 16'h0008, 1'b0);
        check("t5.a40", {16'h0, imem_addr}, 32'h0040);
        check("t5.req", {31'h0, imem_req}, 32'h1);

        // 6: redirect coinciding with imem_ready, then PC wrap
        imem_rdata = 16'hA040;
        tick();
        check_out("t6.o40", 16'hA040, 16'h0040, 1'b1);
        check("t6.a41", {16'h0, imem_addr}, 32'h0041);
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        imem_rdata    = 16'hBEEF;
        tick();
        check("t6.flush", {31'h0, if_flush_out}, 32'h1);
        check("t6.instr", {16'h0, instruction_out}, 32'h0000);
        check("t6.valid", {31'h0, fetch_valid}, 32'h0);
        check("t6.a40",   {16'h0, imem_addr}, 32'h0040);
        branch_target = 16'hFFFF;
        tick();
        branch_taken = 1'b0;
        check("t6.affff", {16'h0, imem_addr}, 32'hFFFF);
        imem_rdata = 16'hAFFF;
        tick();
        check_out("t6.offff", 16'hAFFF, 16'hFFFF, 1'b1);
        check("t6.wrap",   {16'h0, imem_addr}, 32'h0000);
        check("t6.flush0", {31'h0, if_flush_out}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
